div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle controller for RV32 DIV/DIVU/REM/REMU. Sequences one shared CLA_SUB
//  instance through a radix-2 restoring division, one trial subtraction per cycle.
//  Sits beside the single-cycle ALU in EX. The core stalls while Busy=1 and writes
//  back Result when Valid=1.
// PARAMETERS
//  XLEN   32  operand/result width (must be >=2)
//  CNT_W  $clog2(XLEN)  iteration counter width
// PORTS
//  CLK     in   1     single clock, rising edge
//  rst_n   in   1     asynchronous active-low reset
//  Start   in   1     request; sampled only in IDLE
//  Flush   in   1     synchronous abort (pipeline kill)
//  Funct   in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  Rs1     in   XLEN  dividend, latched on accepted Start
//  Rs2     in   XLEN  divisor, latched on accepted Start
//  Busy    out  1     high in CALC/FIX
//  Valid   out  1     one-cycle pulse in DONE
//  Result  out  XLEN  quotient or remainder; holds until next accepted Start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; Busy=0, Valid=0, Result=0; all internal regs 0.
//  Reset mid-operation discards the operation; no Valid is produced.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE->CALC on Start: latch Funct and sign flags.
//    - Signed ops: load |Rs1| into quo and |Rs2| into div (two's complement abs).
//    - rem=0, cnt=XLEN-1.
//   IDLE->DONE on Start, special cases resolved without iteration:
//    - Rs2==0: quotient=all ones, remainder=Rs1 (all four ops).
//    - DIV/REM with Rs1=100..0 and Rs2=all ones: quotient=Rs1, remainder=0.
//   CALC, each cycle:
//    - {rem,quo} <<= 1.
//    - trial = {1'b0,rem_sh} - {1'b0,div}, using the CLA_SUB instance at width XLEN+1
//      with En=1.
//    - If trial[XLEN]==0 (no borrow): rem=trial[XLEN-1:0] and quo[0]=1; else quo[0]=0.
//    - cnt decrements; when cnt==0, go to FIX.
//   CALC->FIX after exactly XLEN iterations.
//   FIX:
//    - Quotient is negated if signed and sign(Rs1)!=sign(Rs2).
//    - Remainder is negated if signed and sign(Rs1)=1.
//    - Result selects per Funct[1]. Go to DONE.
//   DONE: Valid=1 for one cycle, then IDLE. Start in DONE is ignored (not queued).
//  Latency:
//   - Normal: XLEN+2 edges from the Start edge to the Valid cycle (34 for XLEN=32).
//   - Special cases: 1 edge.
//  Start while Busy=1 or in DONE: ignored; no operand overwrite.
//  Flush in CALC/FIX: go to IDLE next edge; no Valid; Result keeps its old value.
//  Flush in IDLE has priority over Start (request dropped).
//  Flush in DONE: Valid is suppressed that cycle.
//  Widths: rem/div regs are XLEN bits; only the trial subtraction is XLEN+1.
//  abs(100..0) = 100..0 is correct when read as unsigned.
// STRUCTURE
//  Shared package rv_div_pkg:
//   - Funct encodings as localparams: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
//   - State encoding localparams: IDLE, CALC, FIX, DONE.
//  One sub-module: CLA_SUB #(.XLEN(XLEN+1)), the trial subtractor.
//  FSM, counter, shift registers and sign fix-up stay inline.
// TESTING
//  1 DIVU 100/7: Busy for 33 cycles, Valid at edge 34, Result=14. REMU same operands -> 2.
//  2 DIV -7/2 -> Result=-3 (FFFFFFFD); REM -7/2 -> Result=-1 (FFFFFFFF);
//    REM 7/-2 -> Result=1.
//  3 DIVU 5/0 -> Valid after 1 edge, Result=FFFFFFFF; REMU 5/0 -> Result=5.
//  4 DIV 80000000/FFFFFFFF -> Valid after 1 edge, Result=80000000; REM same -> Result=0.
//  5 Flush at CALC cycle 10 -> IDLE next edge, no Valid, Result unchanged.
//    Start issued at that edge is not accepted.
//  6 Second Start mid-CALC with other operands -> ignored, first result correct.
//    Then deassert rst_n mid-CALC -> Busy=0, Valid=0, Result=0 asynchronously.

Source files
------------

// File: rtl/rv_div_pkg.sv
// Shared encodings for the RV32 divide sequencer: funct codes, FSM states
// and small decode helpers.
package rv_div_pkg;

    localparam logic [1:0] FN_DIV  = 2'b00;
    localparam logic [1:0] FN_DIVU = 2'b01;
    localparam logic [1:0] FN_REM  = 2'b10;
    localparam logic [1:0] FN_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

    function automatic logic is_signed_op(input logic [1:0] f);
        return (f == FN_DIV) || (f == FN_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] f);
        return (f != FN_DIV) && (f != FN_DIVU);
    endfunction

endpackage

// File: rtl/div_sequencer_cla_sub.sv
// Parallel-prefix (Kogge-Stone) subtractor: o_diff = i_a - i_b when i_en=1,
// otherwise forced to zero.
module CLA_SUB #(
    parameter int XLEN = 33
) (
    input  logic            i_en,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_diff
);

    localparam int LV = $clog2(XLEN - 1);

    logic [XLEN-1:0] w_p0;
    logic [XLEN-1:0] w_carry;
    logic [XLEN-2:0] w_g;
    logic [XLEN-2:0] w_p;

    // a - b = a + ~b + 1; carry-in of 1 folds into every prefix carry below.
    always_comb begin
        w_p0 = i_a ^ ~i_b;
        w_g  = i_a[XLEN-2:0] & ~i_b[XLEN-2:0];
        w_p  = w_p0[XLEN-2:0];
        for (int k = 0; k < LV; k++) begin
            for (int i = XLEN - 2; i >= (1 << k); i--) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i-(1<<k)]);
                w_p[i] = w_p[i] & w_p[i-(1<<k)];
            end
        end
        w_carry = {w_g | w_p, 1'b1};
        o_diff  = i_en ? (w_p0 ^ w_carry) : '0;
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32 DIV/DIVU/REM/REMU controller: radix-2 restoring division,
// one trial subtraction per cycle through a shared CLA_SUB.
module div_sequencer
    import rv_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            Start,
    input  logic            Flush,
    input  logic [1:0]      Funct,
    input  logic [XLEN-1:0] Rs1,
    input  logic [XLEN-1:0] Rs2,
    output logic            Busy,
    output logic            Valid,
    output logic [XLEN-1:0] Result,
    output logic [1:0]      o_dbg_state
);

    // Handshake: Start is accepted only in IDLE without Flush; Busy covers
    // CALC/FIX; Valid pulses for exactly one cycle in DONE unless Flush is high.

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_div;
    logic [XLEN-1:0]   r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_funct;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_signed;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic              w_accept;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN:0]     w_trial_a;
    logic [XLEN:0]     w_trial_b;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_quo_sh;
    logic [XLEN-1:0]   w_fix_q;
    logic [XLEN-1:0]   w_fix_r;

    assign w_signed  = is_signed_op(Funct);
    assign w_div0    = (Rs2 == '0);
    assign w_ovf     = w_signed && (Rs1 == MIN_NEG) && (Rs2 == '1);
    assign w_special = w_div0 || w_ovf;
    assign w_accept  = (r_state == IDLE) && Start && !Flush;

    assign w_special_res = w_div0 ? (is_rem_op(Funct) ? Rs1 : '1)
                                  : (is_rem_op(Funct) ? '0  : Rs1);

    assign w_abs_a = (w_signed && Rs1[XLEN-1]) ? -Rs1 : Rs1;
    assign w_abs_b = (w_signed && Rs2[XLEN-1]) ? -Rs2 : Rs2;

    // The bit shifted out of rem becomes the trial MSB so divisors >= 2^(XLEN-1) work.
    assign w_trial_a = {r_rem, r_quo[XLEN-1]};
    assign w_trial_b = {1'b0, r_div};
    assign w_quo_sh  = {r_quo[XLEN-2:0], ~w_trial[XLEN]};

    assign w_fix_q = r_neg_q ? -r_quo : r_quo;
    assign w_fix_r = r_neg_r ? -r_rem : r_rem;

    CLA_SUB #(.XLEN(XLEN + 1)) u_trial_sub (
        .i_en   (1'b1),
        .i_a    (w_trial_a),
        .i_b    (w_trial_b),
        .o_diff (w_trial)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        Busy         = 1'b0;
        Valid        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = w_special ? DONE : CALC;
            end
            CALC: begin
                Busy = 1'b1;
                if (Flush)              w_next_state = IDLE;
                else if (r_cnt == '0)   w_next_state = FIX;
            end
            FIX: begin
                Busy         = 1'b1;
                w_next_state = Flush ? IDLE : DONE;
            end
            DONE: begin
                Valid        = !Flush;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_funct  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct <= Funct;
                        r_neg_q <= w_signed && (Rs1[XLEN-1] ^ Rs2[XLEN-1]);
                        r_neg_r <= w_signed && Rs1[XLEN-1];
                        r_quo   <= w_abs_a;
                        r_div   <= w_abs_b;
                        r_rem   <= '0;
                        r_cnt   <= CNT_LAST;
                        if (w_special) r_result <= w_special_res;
                    end
                end
                CALC: begin
                    if (!Flush) begin
                        r_quo <= w_quo_sh;
                        r_rem <= w_trial[XLEN] ? w_trial_a[XLEN-1:0] : w_trial[XLEN-1:0];
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!Flush) r_result <= is_rem_op(r_funct) ? w_fix_r : w_fix_q;
                end
                default: ;
            endcase
        end
    end

    assign Result      = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush/restart/reset sequences.
module tb_div_sequencer;
    import rv_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  funct = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    div_sequencer #(.XLEN(32)) dut (
        .CLK         (clk),
        .rst_n       (rst_n),
        .Start       (start),
        .Flush       (flush),
        .Funct       (funct),
        .Rs1         (rs1),
        .Rs2         (rs2),
        .Busy        (busy),
        .Valid       (valid),
        .Result      (result),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // RISC-V divide semantics computed directly with integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
        case (f)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; funct = f; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start  = 1'b0;
        lat    = 1;
        busy_n = busy ? 1 : 0;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_n++;
        end
        res = result;
        @(posedge clk); #1;
        chk("valid_one_cycle", {31'b0, valid}, 32'd0);
    endtask

    task automatic watch_idle(input int n, output int v_cnt, output int b_cnt);
        v_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid) v_cnt++;
            if (busy)  b_cnt++;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] prev;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  f;
        int          lat;
        int          bn;
        int          vc;
        int          bc;

        tbl[0]  = '{FN_DIVU, 32'd100,        32'd7,          32'd14,         34};
        tbl[1]  = '{FN_REMU, 32'd100,        32'd7,          32'd2,          34};
        tbl[2]  = '{FN_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        tbl[3]  = '{FN_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        tbl[4]  = '{FN_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        tbl[5]  = '{FN_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
        tbl[6]  = '{FN_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        tbl[7]  = '{FN_REMU, 32'd5,          32'd0,          32'd5,          1};
        tbl[8]  = '{FN_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
        tbl[9]  = '{FN_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        tbl[10] = '{FN_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        tbl[11] = '{FN_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          34};
        tbl[12] = '{FN_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          34};
        tbl[13] = '{FN_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  34};
        tbl[14] = '{FN_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        tbl[15] = '{FN_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'b0, busy},  32'd0);
        chk("reset_valid",  {31'b0, valid}, 32'd0);
        chk("reset_result", result,         32'd0);
        chk("reset_state",  {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, res, lat, bn);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bn, (tbl[i].lat == 34) ? 33 : 0);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            exp_q.push_back(model(f, a, b));
            do_op(f, a, b, res, lat, bn);
            chk($sformatf("rand%0d_result f=%0d a=%h b=%h", i, f, a, b), res, exp_q.pop_front());
            chk($sformatf("rand%0d_latency", i), lat, model_lat(f, a, b));
        end

        // Flush at CALC cycle 10 with a competing Start
        do_op(FN_DIVU, 32'd1000, 32'd3, res, lat, bn);
        chk("pre_flush_result", res, 32'd333);
        prev = 32'd333;
        @(negedge clk);
        start = 1'b1; funct = FN_DIV; rs1 = 32'd50000; rs2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b1; rs1 = 32'd9; rs2 = 32'd3;
        @(posedge clk); #1;
        chk("flush_busy",   {31'b0, busy},  32'd0);
        chk("flush_valid",  {31'b0, valid}, 32'd0);
        chk("flush_result", result, prev);
        chk("flush_state",  {30'b0, dbg_state}, 32'd0);
        flush = 1'b0; start = 1'b0;
        watch_idle(40, vc, bc);
        chk("flush_no_valid", vc, 0);
        chk("flush_start_dropped", bc, 0);
        chk("flush_result_kept", result, prev);

        // Flush in IDLE beats Start
        @(negedge clk);
        flush = 1'b1; start = 1'b1; funct = FN_DIVU; rs1 = 32'd8; rs2 = 32'd2;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("idle_flush_busy", {31'b0, busy}, 32'd0);
        watch_idle(40, vc, bc);
        chk("idle_flush_no_valid", vc, 0);
        chk("idle_flush_result", result, prev);

        // Second Start mid-CALC is ignored
        @(negedge clk);
        start = 1'b1; funct = FN_DIVU; rs1 = 32'd1000; rs2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk); lat++; end
        @(negedge clk);
        start = 1'b1; funct = FN_REMU; rs1 = 32'd77; rs2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("restart_ignored_result", result, 32'd142);
        chk("restart_ignored_latency", lat, 34);
        @(posedge clk); #1;
        watch_idle(5, vc, bc);
        chk("restart_not_queued", bc, 0);

        // Flush in DONE suppresses Valid
        @(negedge clk);
        start = 1'b1; funct = FN_DIVU; rs1 = 32'd99; rs2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_reached_latency", lat, 34);
        flush = 1'b1;
        #1;
        chk("done_flush_valid", {31'b0, valid}, 32'd0);
        chk("done_flush_result", result, 32'd11);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("done_flush_state", {30'b0, dbg_state}, 32'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; funct = FN_DIV; rs1 = 32'd12345; rs2 = 32'hFFFF_FFFB;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",   {31'b0, busy},  32'd0);
        chk("async_rst_valid",  {31'b0, valid}, 32'd0);
        chk("async_rst_result", result,         32'd0);
        chk("async_rst_state",  {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_idle(40, vc, bc);
        chk("post_rst_no_valid", vc, 0);
        chk("post_rst_no_busy", bc, 0);

        do_op(FN_DIV, 32'd12345, 32'hFFFF_FFFB, res, lat, bn);
        chk("post_rst_op_result", res, model(FN_DIV, 32'd12345, 32'hFFFF_FFFB));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
